// File: rtl/mips_multi_core.sv
// rtl/mips_multi_core.sv - multicycle MIPS core with req/ack instruction and data memory ports
// HALT/run control, illegal-opcode trap, retire strobe and a debug register read port.
module mips_multi_core #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 10,
  parameter int              DADDR_W  = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [4:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               halted,
  output logic               illegal,
  output logic               retire
);

  typedef enum logic [2:0] {S_HALT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  state_t              state, state_n;
  logic [PC_W-1:0]     pc_q;
  logic [31:0]         ir_q;
  logic [DATA_W-1:0]   a_q, b_q, imm_q, alu_q, mdr_q;
  logic [DATA_W-1:0]   regs [32];
  logic                ill_q;

  logic [5:0]          op, funct;
  logic [4:0]          rs, rt, rd, dst;
  logic [4:0]          unused_shamt;
  logic                is_r, r_ok, is_j, is_beq, is_bne, is_addi, is_lw, is_sw, is_halt, legal;
  logic [DATA_W-1:0]   imm_ext, alu_res, wb_data;

  logic ld_ir, ld_ab, ld_alu, ld_mdr, reg_we, pc_jump, pc_branch, set_ill, clr_ill;

  assign op           = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign unused_shamt = ir_q[10:6];
  assign funct        = ir_q[5:0];
  assign imm_ext      = DATA_W'($signed(ir_q[15:0]));

  assign is_r    = (op == OP_RTYPE);
  assign r_ok    = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
  assign is_j    = (op == OP_J);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_halt = (op == OP_HALT);
  assign legal   = (is_r && r_ok) || is_j || is_beq || is_bne || is_addi || is_lw || is_sw || is_halt;

  assign dst     = is_r ? rd : rt;
  assign wb_data = is_lw ? mdr_q : alu_q;

  always_comb begin
    alu_res = a_q + imm_q;
    if (is_r) begin
      case (funct)
        F_SUB:   alu_res = a_q - b_q;
        F_AND:   alu_res = a_q & b_q;
        F_OR:    alu_res = a_q | b_q;
        F_SLT:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HALT;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    retire    = 1'b0;
    ld_ir     = 1'b0;
    ld_ab     = 1'b0;
    ld_alu    = 1'b0;
    ld_mdr    = 1'b0;
    reg_we    = 1'b0;
    pc_jump   = 1'b0;
    pc_branch = 1'b0;
    set_ill   = 1'b0;
    clr_ill   = 1'b0;
    case (state)
      S_HALT: begin
        if (run) begin
          clr_ill = 1'b1;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ld_ir   = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ld_ab = 1'b1;
        if (!legal) begin
          set_ill = 1'b1;
          state_n = S_HALT;
        end else if (is_j) begin
          pc_jump = 1'b1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else if (is_halt) begin
          retire  = 1'b1;
          state_n = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq || is_bne) begin
          pc_branch = is_beq ? (a_q == b_q) : (a_q != b_q);
          retire    = 1'b1;
          state_n   = S_FETCH;
        end else begin
          ld_alu  = 1'b1;
          state_n = (is_lw || is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ack) begin
          if (is_sw) begin
            retire  = 1'b1;
            state_n = S_FETCH;
          end else begin
            ld_mdr  = 1'b1;
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_HALT;
    endcase
  end

  // PC is already post-incremented when a branch resolves, so the offset is relative to PC+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      imm_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      ill_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (ld_ir) begin
        ir_q <= imem_rdata;
        pc_q <= pc_q + 1'b1;
      end
      if (pc_jump)   pc_q <= ir_q[PC_W-1:0];
      if (pc_branch) pc_q <= pc_q + imm_q[PC_W-1:0];
      if (ld_ab) begin
        a_q   <= regs[rs];
        b_q   <= regs[rt];
        imm_q <= imm_ext;
      end
      if (ld_alu) alu_q <= alu_res;
      if (ld_mdr) mdr_q <= dmem_rdata;
      if (reg_we && dst != 5'd0) regs[dst] <= wb_data;
      if (set_ill)      ill_q <= 1'b1;
      else if (clr_ill) ill_q <= 1'b0;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = alu_q[DADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign dbg_data   = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];
  assign halted     = (state == S_HALT);
  assign illegal    = ill_q;

endmodule

// File: tb/tb_mips_multi_core.sv
// tb/tb_mips_multi_core.sv - directed bench for mips_multi_core
// A 32-bit core with wait-state data memory plus a 16-bit core for narrow-datapath arithmetic.
module tb_mips_multi_core;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic        clk, rst_n, run, run16;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted, illegal, retire;
  logic [9:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_data;
  logic [4:0]  dbg_sel, dbg_sel16;

  logic        h_imem_req, h_imem_ack, h_dmem_req, h_dmem_we, h_dmem_ack, h_halted, h_illegal, h_retire;
  logic [9:0]  h_imem_addr, h_dmem_addr;
  logic [31:0] h_imem_rdata;
  logic [15:0] h_dmem_wdata, h_dmem_rdata, h_dbg_data;

  logic [31:0] imem [0:1023];
  logic [31:0] imem16 [0:15];
  logic [31:0] dmem [0:15];
  int          dwait, dcnt;
  logic        mem_clear;
  int          ret_cnt, busy_cnt, sw_hold, lw_hold;
  int          n_tests, n_fail;
  int          r_snap, b_snap, s_snap, l_snap;
  logic        ill_after_run;

  mips_multi_core #(.DATA_W(32), .PC_W(10), .DADDR_W(10), .RESET_PC(10'd0)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .halted(halted), .illegal(illegal), .retire(retire)
  );

  mips_multi_core #(.DATA_W(16), .PC_W(10), .DADDR_W(10), .RESET_PC(10'd0)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .run(run16),
    .imem_req(h_imem_req), .imem_addr(h_imem_addr), .imem_ack(h_imem_ack), .imem_rdata(h_imem_rdata),
    .dmem_req(h_dmem_req), .dmem_we(h_dmem_we), .dmem_addr(h_dmem_addr), .dmem_wdata(h_dmem_wdata),
    .dmem_ack(h_dmem_ack), .dmem_rdata(h_dmem_rdata),
    .dbg_sel(dbg_sel16), .dbg_data(h_dbg_data),
    .halted(h_halted), .illegal(h_illegal), .retire(h_retire)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign imem_ack   = imem_req;
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && (dcnt == dwait);
  assign dmem_rdata = dmem[dmem_addr[3:0]];

  assign h_imem_ack   = h_imem_req;
  assign h_imem_rdata = imem16[h_imem_addr[3:0]];
  assign h_dmem_ack   = h_dmem_req;
  assign h_dmem_rdata = 16'h0;

  always @(posedge clk) begin
    if (!dmem_req || dmem_ack) dcnt <= 0;
    else                       dcnt <= dcnt + 1;
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) dmem[i] <= 32'h0;
    end else if (dmem_req && dmem_ack && dmem_we) begin
      dmem[dmem_addr[3:0]] <= dmem_wdata;
    end
  end

  always @(negedge clk) begin
    if (retire)  ret_cnt  <= ret_cnt + 1;
    if (!halted) busy_cnt <= busy_cnt + 1;
    if (dmem_req && dmem_we && dmem_addr == 10'd4 && dmem_wdata == 32'd5) sw_hold <= sw_hold + 1;
    if (dmem_req && !dmem_we && dmem_addr == 10'd4) lw_hold <= lw_hold + 1;
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic clear_imem;
    for (int i = 0; i < 1024; i++) imem[i] = HALT_W;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n     = 1'b0;
    mem_clear = 1'b1;
    @(negedge clk);
    mem_clear = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic snap;
    r_snap = ret_cnt;
    b_snap = busy_cnt;
    s_snap = sw_hold;
    l_snap = lw_hold;
  endtask

  task automatic run_to_halt(input string tag);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    ill_after_run = illegal;
    for (int i = 0; i < 2000; i++) begin
      if (halted) break;
      @(negedge clk);
    end
    check({tag, " halted"}, {31'b0, halted}, 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    ret_cnt = 0; busy_cnt = 0; sw_hold = 0; lw_hold = 0;
    dcnt = 0; dwait = 0; mem_clear = 1'b0;
    rst_n = 1'b0; run = 1'b0; run16 = 1'b0; dbg_sel = 5'd0; dbg_sel16 = 5'd0;
    clear_imem();
    for (int i = 0; i < 16; i++) imem16[i] = HALT_W;
    @(negedge clk);

    check("rst halted",   {31'b0, halted},   32'd1);
    check("rst imem_req", {31'b0, imem_req}, 32'd0);
    check("rst dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst retire",   {31'b0, retire},   32'd0);
    check("rst illegal",  {31'b0, illegal},  32'd0);
    check("rst pc",       {22'b0, imem_addr}, 32'd0);
    check_reg("rst r1", 5'd1, 32'd0);

    // addi/add with a negative immediate
    do_reset();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    snap();
    run_to_halt("t1");
    check_reg("t1 r1", 5'd1, 32'd5);
    check_reg("t1 r2", 5'd2, 32'hFFFFFFFD);
    check_reg("t1 r3", 5'd3, 32'd2);
    check("t1 retires", ret_cnt - r_snap, 32'd4);
    check("t1 cycles",  busy_cnt - b_snap, 32'd14);

    // store then load through a 3-wait-state data memory
    do_reset();
    clear_imem();
    dwait = 3;
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd4);
    imem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd4);
    snap();
    run_to_halt("t2");
    check_reg("t2 r4", 5'd4, 32'd5);
    check("t2 dmem[4]", dmem[4], 32'd5);
    check("t2 sw hold", sw_hold - s_snap, 32'd4);
    check("t2 lw hold", lw_hold - l_snap, 32'd4);
    check("t2 retires", ret_cnt - r_snap, 32'd4);
    check("t2 cycles",  busy_cnt - b_snap, 32'd21);
    dwait = 0;

    // bne countdown loop, body runs 3 times
    do_reset();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
    imem[1] = enc_i(6'h08, 5'd2, 5'd2, 16'd1);
    imem[2] = enc_i(6'h08, 5'd1, 5'd1, 16'hFFFF);
    imem[3] = enc_i(6'h05, 5'd1, 5'd0, 16'hFFFD);
    snap();
    run_to_halt("t3");
    check_reg("t3 r1", 5'd1, 32'd0);
    check_reg("t3 r2", 5'd2, 32'd3);
    check("t3 retires", ret_cnt - r_snap, 32'd11);
    check("t3 cycles",  busy_cnt - b_snap, 32'd39);

    // jump to the top of memory, PC wraps to 0, beq falls through to halt
    do_reset();
    clear_imem();
    imem[0]    = enc_i(6'h04, 5'd6, 5'd0, 16'd1);
    imem[2]    = {6'h02, 26'd1022};
    imem[1022] = enc_i(6'h08, 5'd0, 5'd5, 16'd7);
    imem[1023] = enc_i(6'h08, 5'd0, 5'd6, 16'd9);
    snap();
    run_to_halt("t3w");
    check_reg("t3w r5", 5'd5, 32'd7);
    check_reg("t3w r6", 5'd6, 32'd9);
    check("t3w pc",      {22'b0, imem_addr}, 32'd2);
    check("t3w retires", ret_cnt - r_snap, 32'd6);
    check("t3w cycles",  busy_cnt - b_snap, 32'd18);

    // illegal opcode, resume, then illegal funct
    do_reset();
    clear_imem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = 32'hEC000000;
    imem[2] = enc_i(6'h08, 5'd0, 5'd2, 16'd6);
    imem[3] = enc_r(5'd1, 5'd1, 5'd7, 6'h26);
    snap();
    run_to_halt("t4");
    check("t4 illegal", {31'b0, illegal}, 32'd1);
    check_reg("t4 r1", 5'd1, 32'd5);
    check_reg("t4 r2", 5'd2, 32'd0);
    check("t4 pc",      {22'b0, imem_addr}, 32'd2);
    check("t4 retires", ret_cnt - r_snap, 32'd1);
    check("t4 cycles",  busy_cnt - b_snap, 32'd6);
    run_to_halt("t4r");
    check("t4r illegal cleared", {31'b0, ill_after_run}, 32'd0);
    check("t4r illegal funct",   {31'b0, illegal}, 32'd1);
    check_reg("t4r r2", 5'd2, 32'd6);
    check_reg("t4r r7", 5'd7, 32'd0);
    check("t4r pc",      {22'b0, imem_addr}, 32'd4);
    check("t4r retires", ret_cnt - r_snap, 32'd2);

    // reset while a store is waiting for ack
    do_reset();
    clear_imem();
    dwait = 10;
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dmem_req) break;
      @(negedge clk);
    end
    check("t5 req seen", {31'b0, dmem_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5 req dropped", {31'b0, dmem_req}, 32'd0);
    check("t5 halted",      {31'b0, halted},   32'd1);
    check("t5 pc",          {22'b0, imem_addr}, 32'd0);
    check_reg("t5 r1", 5'd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("t5 no store", dmem[8], 32'd0);
    rst_n = 1'b1;
    dwait = 0;

    // 16-bit datapath: signed wrap, slt, write to r0 discarded
    imem16[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h7FFF);
    imem16[1] = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
    imem16[2] = enc_r(5'd1, 5'd0, 5'd2, 6'h2A);
    imem16[3] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);
    @(negedge clk);
    run16 = 1'b1;
    @(negedge clk);
    run16 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (h_halted) break;
      @(negedge clk);
    end
    check("t6 halted", {31'b0, h_halted}, 32'd1);
    check("t6 illegal", {31'b0, h_illegal}, 32'd0);
    dbg_sel16 = 5'd1; #1;
    check("t6 r1", {16'b0, h_dbg_data}, 32'h8000);
    dbg_sel16 = 5'd2; #1;
    check("t6 r2", {16'b0, h_dbg_data}, 32'd1);
    dbg_sel16 = 5'd0; #1;
    check("t6 r0", {16'b0, h_dbg_data}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
